// File: rtl/program_mem_responder.sv
// ---------------------------------------------------------------------------
// program_mem_responder
//
// Responder end of the instruction-fetch read handshake. Up to NUM_CONSUMERS
// fetchers share one program-memory read channel. Requests are granted
// round-robin, and only one memory read is outstanding at any time. A
// consumer's ready/data pair is held until that consumer drops its request.
//
// Optional feature (compile-time macro PROGRAM_MEM_LAST_LINE_REUSE_EN):
//   A one-entry buffer keeps the address and data of the most recent memory
//   completion. A request to that same address is answered from the buffer
//   without touching program memory. Program memory is read-only, so the
//   buffer never needs invalidation; only reset clears it. When the macro is
//   undefined, every request goes to memory and the buffer does not exist.
//
// Parameters:
//   ADDRESS_BITS   program memory address width
//   DATA_BITS      instruction word width
//   NUM_CONSUMERS  number of fetcher ports (>= 1)
//
// Ports:
//   clk                    clock; all state updates on the rising edge
//   reset                  synchronous, active-high reset
//   consumer_read_valid    per-consumer request, held until ready is seen
//   consumer_read_address  packed addresses; consumer i at [i*ADDRESS_BITS +: ADDRESS_BITS]
//   consumer_read_ready    per-consumer response valid (registered)
//   consumer_read_data     packed instruction words, same packing (registered)
//   mem_read_valid         request to program memory (registered)
//   mem_read_address       address for program memory (registered)
//   mem_read_ready         memory data valid
//   mem_read_data          instruction word from memory
// ---------------------------------------------------------------------------
module program_mem_responder #(
  parameter int ADDRESS_BITS  = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_CONSUMERS-1:0]              consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDRESS_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]              consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0]    consumer_read_data,
  output logic                                  mem_read_valid,
  output logic [ADDRESS_BITS-1:0]               mem_read_address,
  input  logic                                  mem_read_ready,
  input  logic [DATA_BITS-1:0]                  mem_read_data
);

  // Index width; a single consumer still needs a 1-bit index register.
  localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    READ_WAITING = 2'd1,
    RELAYING     = 2'd2
  } state_e;

  state_e                            state_q;
  logic [IDX_W-1:0]                  idx_q;
  logic [IDX_W-1:0]                  rr_q;
  logic [IDX_W-1:0]                  rr_d;
  logic [NUM_CONSUMERS-1:0]          ready_q;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] data_q;
  logic                              mem_valid_q;
  logic [ADDRESS_BITS-1:0]           mem_addr_q;

  logic                              sel_found_s;
  logic [IDX_W-1:0]                  sel_idx_s;
  logic [ADDRESS_BITS-1:0]           sel_addr_s;

`ifdef PROGRAM_MEM_LAST_LINE_REUSE_EN
  logic                              hit_valid_q;
  logic [ADDRESS_BITS-1:0]           hit_address_q;
  logic [DATA_BITS-1:0]              hit_data_q;
  logic                              hit_s;
`endif

  // (base + off) mod NUM_CONSUMERS. Both operands are below NUM_CONSUMERS,
  // so one conditional subtraction is enough.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int               off);
    int sum_s;
    sum_s = int'(base) + off;
    if (sum_s >= NUM_CONSUMERS) begin
      sum_s = sum_s - NUM_CONSUMERS;
    end else begin
      sum_s = sum_s;
    end
    return sum_s[IDX_W-1:0];
  endfunction

  // Round-robin scan starting at rr_q: first consumer requesting and not
  // currently being answered wins.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    for (int off = 0; off < NUM_CONSUMERS; off++) begin
      if (!sel_found_s &&
          consumer_read_valid[wrap_add(rr_q, off)] &&
          !ready_q[wrap_add(rr_q, off)]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = wrap_add(rr_q, off);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Address of the selected consumer.
  always_comb begin
    sel_addr_s = consumer_read_address[int'(sel_idx_s)*ADDRESS_BITS +: ADDRESS_BITS];
  end

  // Pointer value after finishing with idx_q: the consumer just served gets
  // lowest priority in the next scan.
  always_comb begin
    if (idx_q == IDX_W'(NUM_CONSUMERS - 1)) begin
      rr_d = '0;
    end else begin
      rr_d = idx_q + 1'b1;
    end
  end

`ifdef PROGRAM_MEM_LAST_LINE_REUSE_EN
  // Selected request matches the last completed memory read.
  always_comb begin
    if (hit_valid_q && (sel_addr_s == hit_address_q)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end
`endif

  // Main FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rr_q        <= '0;
      ready_q     <= '0;
      data_q      <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
`ifdef PROGRAM_MEM_LAST_LINE_REUSE_EN
      hit_valid_q   <= 1'b0;
      hit_address_q <= '0;
      hit_data_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // mem_read_ready is deliberately ignored here: a late completion
          // from a read aborted by reset must not be taken as valid data.
          if (sel_found_s) begin
            idx_q <= sel_idx_s;
`ifdef PROGRAM_MEM_LAST_LINE_REUSE_EN
            if (hit_s) begin
              data_q[int'(sel_idx_s)*DATA_BITS +: DATA_BITS] <= hit_data_q;
              ready_q[sel_idx_s] <= 1'b1;
              state_q            <= RELAYING;
            end else begin
              mem_valid_q <= 1'b1;
              mem_addr_q  <= sel_addr_s;
              state_q     <= READ_WAITING;
            end
`else
            mem_valid_q <= 1'b1;
            mem_addr_q  <= sel_addr_s;
            state_q     <= READ_WAITING;
`endif
          end else begin
            state_q <= IDLE;
          end
        end

        READ_WAITING: begin
          // The read completes even if the consumer has already given up;
          // the memory side must see a clean handshake.
          if (mem_read_ready) begin
            mem_valid_q <= 1'b0;
            data_q[int'(idx_q)*DATA_BITS +: DATA_BITS] <= mem_read_data;
            ready_q[idx_q] <= 1'b1;
            state_q        <= RELAYING;
`ifdef PROGRAM_MEM_LAST_LINE_REUSE_EN
            hit_valid_q   <= 1'b1;
            hit_address_q <= mem_addr_q;
            hit_data_q    <= mem_read_data;
`endif
          end else begin
            state_q <= READ_WAITING;
          end
        end

        RELAYING: begin
          if (!consumer_read_valid[idx_q]) begin
            ready_q[idx_q] <= 1'b0;
            rr_q           <= rr_d;
            state_q        <= IDLE;
          end else begin
            state_q <= RELAYING;
          end
        end

        default: begin
          state_q     <= IDLE;
          mem_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign consumer_read_ready = ready_q;
  assign consumer_read_data  = data_q;
  assign mem_read_valid      = mem_valid_q;
  assign mem_read_address    = mem_addr_q;

endmodule

// File: tb/tb_program_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_program_mem_responder
//
// Self-checking bench for program_mem_responder (default parameters: 8-bit
// addresses, 16-bit words, 4 consumers). A table of single-transfer vectors
// is run in a loop, followed by hand-written sequences for latency,
// simultaneous requests, fairness, reset mid-read, consumer abort and
// last-line reuse (PROGRAM_MEM_LAST_LINE_REUSE_EN).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_program_mem_responder;

  localparam int AB = 8;
  localparam int DB = 16;
  localparam int NC = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [NC-1:0]    valid_s;
  logic [NC*AB-1:0] addr_s;
  logic [NC-1:0]    ready_s;
  logic [NC*DB-1:0] data_s;
  logic             mvalid_s;
  logic [AB-1:0]    maddr_s;
  logic             mready_s;
  logic [DB-1:0]    mdata_s;

  int checks = 0;
  int errors = 0;

  logic [DB-1:0] exp_data [NC];

  typedef struct {
    int            cons;
    logic [AB-1:0] addr;
    logic [DB-1:0] mem_word;
    int            delay;
    logic [AB-1:0] exp_maddr;
    logic [DB-1:0] exp_word;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  program_mem_responder #(
    .ADDRESS_BITS (AB),
    .DATA_BITS    (DB),
    .NUM_CONSUMERS(NC)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .consumer_read_valid  (valid_s),
    .consumer_read_address(addr_s),
    .consumer_read_ready  (ready_s),
    .consumer_read_data   (data_s),
    .mem_read_valid       (mvalid_s),
    .mem_read_address     (maddr_s),
    .mem_read_ready       (mready_s),
    .mem_read_data        (mdata_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DB-1:0] word_of(input int c);
    return data_s[c*DB +: DB];
  endfunction

  function automatic logic [NC-1:0] onehot(input int c);
    logic [NC-1:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    reset    = 1'b1;
    valid_s  = '0;
    mready_s = 1'b0;
    mdata_s  = '0;
    tick();
    reset = 1'b0;
    for (int j = 0; j < NC; j++) exp_data[j] = '0;
  endtask

  // Bounded wait for a memory request; expiry counts as a failed check.
  task automatic wait_mvalid(input string nm);
    int n;
    n = 0;
    while (mvalid_s !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk({nm, " mem_read_valid rise"}, 64'(mvalid_s), 64'd1);
  endtask

  task automatic respond(input logic [DB-1:0] d);
    mready_s = 1'b1;
    mdata_s  = d;
    tick();
    mready_s = 1'b0;
    mdata_s  = '0;
  endtask

  task automatic check_others(input string nm, input int c);
    for (int j = 0; j < NC; j++) begin
      if (j != c) begin
        chk({nm, " other ready"}, 64'(ready_s[j]), 64'd0);
        chk({nm, " other data"}, 64'(word_of(j)), 64'(exp_data[j]));
      end
    end
  endtask

  // One complete transfer for consumer c; the fetcher drops valid as soon
  // as it has seen ready.
  task automatic fetch(input string nm, input int c, input logic [AB-1:0] a,
                       input logic [DB-1:0] d, input int delay,
                       input logic [AB-1:0] exp_a, input logic [DB-1:0] exp_d);
    valid_s[c]          = 1'b1;
    addr_s[c*AB +: AB]  = a;
    wait_mvalid(nm);
    chk({nm, " mem addr"}, 64'(maddr_s), 64'(exp_a));
    for (int k = 0; k < delay; k++) begin
      tick();
      chk({nm, " mem valid held"}, 64'(mvalid_s), 64'd1);
      chk({nm, " addr held"}, 64'(maddr_s), 64'(exp_a));
      chk({nm, " ready early"}, 64'(ready_s), 64'd0);
    end
    respond(d);
    chk({nm, " ready"}, 64'(ready_s), 64'(onehot(c)));
    chk({nm, " data"}, 64'(word_of(c)), 64'(exp_d));
    chk({nm, " mem valid drop"}, 64'(mvalid_s), 64'd0);
    valid_s[c] = 1'b0;
    tick();
    chk({nm, " ready fall"}, 64'(ready_s), 64'd0);
    exp_data[c] = exp_d;
    check_others(nm, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{cons: 1, addr: 8'h3C, mem_word: 16'hCAFE, delay: 0, exp_maddr: 8'h3C, exp_word: 16'hCAFE};
    vecs[1] = '{cons: 3, addr: 8'hFF, mem_word: 16'hFFFF, delay: 2, exp_maddr: 8'hFF, exp_word: 16'hFFFF};
    vecs[2] = '{cons: 2, addr: 8'h00, mem_word: 16'h0001, delay: 1, exp_maddr: 8'h00, exp_word: 16'h0001};
    vecs[3] = '{cons: 0, addr: 8'h80, mem_word: 16'h8000, delay: 4, exp_maddr: 8'h80, exp_word: 16'h8000};
    vecs[4] = '{cons: 1, addr: 8'h7F, mem_word: 16'h0000, delay: 1, exp_maddr: 8'h7F, exp_word: 16'h0000};

    reset    = 1'b1;
    valid_s  = '0;
    addr_s   = '0;
    mready_s = 1'b0;
    mdata_s  = '0;
    for (int j = 0; j < NC; j++) exp_data[j] = '0;
    tick();
    tick();
    chk("reset ready", 64'(ready_s), 64'd0);
    chk("reset data", 64'(data_s), 64'd0);
    chk("reset mem valid", 64'(mvalid_s), 64'd0);
    chk("reset mem addr", 64'(maddr_s), 64'd0);
    reset = 1'b0;
    tick();

    // Exact latency: single consumer 0 at 0x05.
    valid_s[0]     = 1'b1;
    addr_s[0 +: AB] = 8'h05;
    tick();
    chk("lat mem valid", 64'(mvalid_s), 64'd1);
    chk("lat mem addr", 64'(maddr_s), 64'h05);
    chk("lat ready before mem", 64'(ready_s), 64'd0);
    tick();
    tick();
    chk("lat mem valid held", 64'(mvalid_s), 64'd1);
    respond(16'h1234);
    chk("lat ready", 64'(ready_s), 64'h1);
    chk("lat data", 64'(word_of(0)), 64'h1234);
    chk("lat mem valid drop", 64'(mvalid_s), 64'd0);
    tick();
    chk("lat ready second cycle", 64'(ready_s), 64'h1);
    valid_s[0] = 1'b0;
    tick();
    chk("lat ready fall", 64'(ready_s), 64'd0);
    exp_data[0] = 16'h1234;

    // Table of single transfers.
    for (int v = 0; v < 5; v++) begin
      fetch($sformatf("vec%0d", v), vecs[v].cons, vecs[v].addr, vecs[v].mem_word,
            vecs[v].delay, vecs[v].exp_maddr, vecs[v].exp_word);
    end

    // Simultaneous requests from consumers 0,1,2 after reset (rr = 0).
    do_reset();
    addr_s  = {8'h00, 8'h30, 8'h20, 8'h10};
    valid_s = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      wait_mvalid($sformatf("sim%0d", k));
      chk($sformatf("sim%0d mem addr", k), 64'(maddr_s), 64'(8'h10 * (k + 1)));
      tick();
      respond(16'hA000 + 16'(k));
      chk($sformatf("sim%0d ready", k), 64'(ready_s), 64'(onehot(k)));
      valid_s[k] = 1'b0;
      tick();
      chk($sformatf("sim%0d ready fall", k), 64'(ready_s), 64'd0);
    end
    chk("sim data0", 64'(word_of(0)), 64'hA000);
    chk("sim data1", 64'(word_of(1)), 64'hA001);
    chk("sim data2", 64'(word_of(2)), 64'hA002);
    chk("sim data3 untouched", 64'(word_of(3)), 64'd0);
    chk("sim ready3 untouched", 64'(ready_s[3]), 64'd0);

    // Fairness: consumer 0 re-requests at once while consumer 1 waits.
    do_reset();
    addr_s  = {8'h00, 8'h00, 8'h20, 8'h10};
    valid_s = 4'b0011;
    wait_mvalid("fair first");
    chk("fair first addr", 64'(maddr_s), 64'h10);
    respond(16'h0110);
    chk("fair first ready", 64'(ready_s), 64'h1);
    valid_s[0] = 1'b0;
    tick();
    valid_s[0]       = 1'b1;
    addr_s[0 +: AB]  = 8'h11;
    wait_mvalid("fair second");
    chk("fair second addr", 64'(maddr_s), 64'h20);
    respond(16'h0220);
    chk("fair second ready", 64'(ready_s), 64'h2);
    chk("fair second data", 64'(word_of(1)), 64'h0220);
    valid_s[1] = 1'b0;
    tick();
    wait_mvalid("fair third");
    chk("fair third addr", 64'(maddr_s), 64'h11);
    respond(16'h0111);
    chk("fair third ready", 64'(ready_s), 64'h1);
    chk("fair third data", 64'(word_of(0)), 64'h0111);
    valid_s[0] = 1'b0;
    tick();

    // Reset while a read is outstanding; a late memory ready is ignored.
    valid_s[2]        = 1'b1;
    addr_s[2*AB +: AB] = 8'h40;
    wait_mvalid("rst");
    reset   = 1'b1;
    valid_s = '0;
    tick();
    chk("rst mem valid", 64'(mvalid_s), 64'd0);
    chk("rst ready", 64'(ready_s), 64'd0);
    chk("rst data", 64'(data_s), 64'd0);
    reset = 1'b0;
    for (int j = 0; j < NC; j++) exp_data[j] = '0;
    tick();
    tick();
    respond(16'hDEAD);
    chk("rst late ready ignored", 64'(ready_s), 64'd0);
    chk("rst late mem valid", 64'(mvalid_s), 64'd0);
    tick();
    chk("rst no pulse", 64'(ready_s), 64'd0);
    fetch("rst after", 2, 8'h41, 16'h4141, 1, 8'h41, 16'h4141);

    // Consumer abort while the read is outstanding.
    valid_s[3]         = 1'b1;
    addr_s[3*AB +: AB] = 8'h77;
    wait_mvalid("abort");
    valid_s[3] = 1'b0;
    tick();
    chk("abort mem valid held", 64'(mvalid_s), 64'd1);
    respond(16'h5A5A);
    chk("abort ready pulse", 64'(ready_s), 64'h8);
    chk("abort data", 64'(word_of(3)), 64'h5A5A);
    tick();
    chk("abort ready fall", 64'(ready_s), 64'd0);
    exp_data[3] = 16'h5A5A;
    fetch("abort next", 1, 8'h78, 16'h7878, 0, 8'h78, 16'h7878);

    // Last-line reuse: second request to 0x05 from another consumer.
    do_reset();
    fetch("reuse first", 0, 8'h05, 16'hBEEF, 1, 8'h05, 16'hBEEF);
    valid_s[1]       = 1'b1;
    addr_s[AB +: AB] = 8'h05;
    tick();
`ifdef PROGRAM_MEM_LAST_LINE_REUSE_EN
    chk("reuse no mem valid", 64'(mvalid_s), 64'd0);
    chk("reuse ready", 64'(ready_s), 64'h2);
    chk("reuse data", 64'(word_of(1)), 64'hBEEF);
`else
    chk("reuse mem valid", 64'(mvalid_s), 64'd1);
    chk("reuse mem addr", 64'(maddr_s), 64'h05);
    respond(16'hBEEF);
    chk("reuse ready", 64'(ready_s), 64'h2);
    chk("reuse data", 64'(word_of(1)), 64'hBEEF);
`endif
    valid_s[1] = 1'b0;
    tick();
    chk("reuse ready fall", 64'(ready_s), 64'd0);
    chk("reuse data0 kept", 64'(word_of(0)), 64'hBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
